// File: rtl/jump_predict_btb_if.sv
`default_nettype none
// ============================================================================
// Module   : jump_predict_btb_if
// Brief    : Bundle of the fetch-side prediction port and the EX-side
//            resolution/redirect port of jump_predict_btb.
// Revision : 1.0 - initial release
// ============================================================================
interface jump_predict_btb_if #(
    parameter int ADDR_W = 32
);
    // Fetch-side lookup
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    // EX-side resolution
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic [31:0]       ex_ins;
    logic              ex_is_jump;
    logic              ex_is_branch;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;

    // Redirect back to fetch
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [15:0]       mispredict_cnt;

    // Pipeline side: drives fetch PC and resolutions, consumes predictions
    modport master (
        output if_pc,
        output ex_valid, ex_pc, ex_ins, ex_is_jump, ex_is_branch,
        output ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_hit, pred_taken, pred_target,
        input  redirect, redirect_pc, mispredict_cnt
    );

    // Predictor side
    modport slave (
        input  if_pc,
        input  ex_valid, ex_pc, ex_ins, ex_is_jump, ex_is_branch,
        input  ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_hit, pred_taken, pred_target,
        output redirect, redirect_pc, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/jump_predict_btb.sv
`default_nettype none
// ============================================================================
// Module   : jump_predict_btb
// Brief    : Direct-mapped branch target buffer with J/JAL target generation,
//            zero-cycle prediction and registered mispredict redirect.
//            Optional macro BTB_COUNTER_EN adds a 2-bit saturating counter
//            per entry; without it a not-taken hit invalidates the entry.
// Revision : 1.0 - initial release
// ============================================================================
module jump_predict_btb #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    jump_predict_btb_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Jump target splices the 26-bit index under the top four PC bits
    if (ADDR_W < 29) begin : g_addr_w_check
        $error("jump_predict_btb: ADDR_W must be at least 29");
    end

    // Table storage
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [TAG_W-1:0]  tag_d    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];
    logic [ADDR_W-1:0] target_d [DEPTH];
`ifdef BTB_COUNTER_EN
    logic [1:0]        ctr_q    [DEPTH];
    logic [1:0]        ctr_d    [DEPTH];
`endif

    // Redirect / statistics state
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [15:0]       cnt_q, cnt_d;

    // Lookup fields
    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    logic              lookup_hit;
    logic              ex_hit;

    // Resolution
    logic              ex_ctl;
    logic              actual_taken;
    logic [ADDR_W-1:0] jtarget;
    logic [ADDR_W-1:0] actual_target;
    logic [ADDR_W-1:0] next_pc;
    logic              mispredict;

    // Bits that carry no information for this unit
    logic              unused_bits;
    assign unused_bits = &{1'b0, bus.ex_ins[31:26], bus.if_pc[1:0]};

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = bus.if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[ADDR_W-1:IDX_W+2];

    // Fetch-side prediction, purely from registered table state (read-old)
    always_comb begin
        lookup_hit      = valid_q[if_idx] & (tag_q[if_idx] == if_tag);
        bus.pred_hit    = lookup_hit;
        bus.pred_target = lookup_hit ? target_q[if_idx] : '0;
`ifdef BTB_COUNTER_EN
        bus.pred_taken  = lookup_hit & ctr_q[if_idx][1];
`else
        bus.pred_taken  = lookup_hit;
`endif
    end

    // Resolve the EX instruction and compare with what fetch predicted
    always_comb begin
        ex_ctl        = bus.ex_valid & (bus.ex_is_jump | bus.ex_is_branch);
        jtarget       = {bus.ex_pc[ADDR_W-1:28], bus.ex_ins[25:0], 2'b00};
        actual_taken  = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_taken);
        actual_target = bus.ex_is_jump ? jtarget : bus.ex_target;
        next_pc       = actual_taken ? actual_target : bus.ex_pc + ADDR_W'(4);
        ex_hit        = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
        mispredict    = ex_ctl &
                        ((actual_taken != bus.ex_pred_taken) |
                         (actual_taken & (actual_target != bus.ex_pred_target)));
    end

    // Next-state of the table: allocate/refresh on taken, demote on not-taken hit
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
`ifdef BTB_COUNTER_EN
        ctr_d    = ctr_q;
`endif
        if (ex_ctl) begin
            if (actual_taken) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = actual_target;
`ifdef BTB_COUNTER_EN
                if (bus.ex_is_jump)
                    ctr_d[ex_idx] = 2'b11;
                else if (ex_hit)
                    ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b11) ? 2'b11
                                                             : ctr_q[ex_idx] + 2'b01;
                else
                    ctr_d[ex_idx] = 2'b10;
`endif
            end else if (ex_hit) begin
`ifdef BTB_COUNTER_EN
                ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00
                                                         : ctr_q[ex_idx] - 2'b01;
`else
                valid_d[ex_idx] = 1'b0;
`endif
            end
        end
    end

    // Next-state of redirect pulse and saturating mispredict counter
    always_comb begin
        redirect_d    = mispredict;
        redirect_pc_d = mispredict ? next_pc : '0;
        cnt_d         = (mispredict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    // Control state: valid bits, counters and redirect, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
`ifdef BTB_COUNTER_EN
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
`endif
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            valid_q       <= valid_d;
`ifdef BTB_COUNTER_EN
            ctr_q         <= ctr_d;
`endif
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
        end
    end

    // Payload storage: meaningless while the valid bit is clear, so no reset
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mispredict_cnt = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_jump_predict_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_predict_btb
// Brief    : Directed self-checking bench for jump_predict_btb (DEPTH 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_predict_btb;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    jump_predict_btb_if #(.ADDR_W(32)) bus ();

    jump_predict_btb #(.ADDR_W(32), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ex_set(input logic jmp, input logic br, input logic tk,
                          input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
        bus.ex_valid       = 1'b1;
        bus.ex_is_jump     = jmp;
        bus.ex_is_branch   = br;
        bus.ex_taken       = tk;
        bus.ex_pc          = pc;
        bus.ex_ins         = ins;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
    endtask

    task automatic ex_clear();
        bus.ex_valid     = 1'b0;
        bus.ex_is_jump   = 1'b0;
        bus.ex_is_branch = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_pc = '0;
        bus.ex_pc = '0; bus.ex_ins = '0; bus.ex_target = '0;
        bus.ex_taken = 1'b0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
        ex_clear();
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.if_pc = 32'h1230_0000 + 32'(i * 4);
            #1;
            nvec++;
            if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
                nerr++;
                $display("FAIL reset_sweep idx=%0d got hit=%b tk=%b tgt=%h exp 0/0/0",
                         i, bus.pred_hit, bus.pred_taken, bus.pred_target);
            end
        end
        nvec++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.mispredict_cnt !== 16'h0) begin
            nerr++;
            $display("FAIL reset_outputs got redir=%b pc=%h cnt=%h exp 0/0/0",
                     bus.redirect, bus.redirect_pc, bus.mispredict_cnt);
        end
        step();
    endtask

    task automatic test_jump();
        ex_set(1'b1, 1'b0, 1'b0, 32'h4000_0100, 32'h0800_0040, 32'h0, 1'b0, 32'h0);
        step();
        ex_clear();
        nvec++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h4000_0100 || bus.mispredict_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL jump_redirect got redir=%b pc=%h cnt=%0d exp 1/40000100/1",
                     bus.redirect, bus.redirect_pc, bus.mispredict_cnt);
        end
        bus.if_pc = 32'h4000_0100;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h4000_0100) begin
            nerr++;
            $display("FAIL jump_lookup got hit=%b tk=%b tgt=%h exp 1/1/40000100",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
        step();
        nvec++;
        if (bus.redirect !== 1'b0) begin
            nerr++;
            $display("FAIL jump_pulse_width got redir=%b exp 0", bus.redirect);
        end
    endtask

    task automatic test_branch_correct();
        ex_set(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 32'h0000_0400, 1'b1, 32'h0000_0400);
        step();
        ex_clear();
        nvec++;
        if (bus.redirect !== 1'b0 || bus.mispredict_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL branch_correct got redir=%b cnt=%0d exp 0/1",
                     bus.redirect, bus.mispredict_cnt);
        end
        bus.if_pc = 32'h0000_0020;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h0000_0400) begin
            nerr++;
            $display("FAIL branch_alloc got hit=%b tk=%b tgt=%h exp 1/1/00000400",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_not_taken();
        ex_set(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0400, 1'b1, 32'h0000_0400);
        step();
        ex_clear();
        nvec++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_0024 || bus.mispredict_cnt !== 16'd2) begin
            nerr++;
            $display("FAIL not_taken_redirect got redir=%b pc=%h cnt=%0d exp 1/00000024/2",
                     bus.redirect, bus.redirect_pc, bus.mispredict_cnt);
        end
        bus.if_pc = 32'h0000_0020;
        #1;
        nvec++;
`ifdef BTB_COUNTER_EN
        if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0000_0400) begin
            nerr++;
            $display("FAIL not_taken_entry got hit=%b tk=%b tgt=%h exp 1/0/00000400",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
`else
        if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
            nerr++;
            $display("FAIL not_taken_entry got hit=%b tk=%b tgt=%h exp 0/0/00000000",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
`endif
    endtask

    task automatic test_read_old();
        bus.if_pc = 32'h0000_000C;
        ex_set(1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'h0, 32'h0000_0800, 1'b0, 32'h0);
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b0) begin
            nerr++;
            $display("FAIL read_old_alloc got hit=%b exp 0", bus.pred_hit);
        end
        step();
        ex_set(1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'h0, 32'h0000_0900, 1'b1, 32'h0000_0800);
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h0000_0800 ||
            bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_0800) begin
            nerr++;
            $display("FAIL read_old_update got hit=%b tgt=%h redir=%b pc=%h exp 1/00000800/1/00000800",
                     bus.pred_hit, bus.pred_target, bus.redirect, bus.redirect_pc);
        end
        step();
        ex_clear();
        #1;
        nvec++;
        if (bus.pred_target !== 32'h0000_0900 || bus.redirect_pc !== 32'h0000_0900 ||
            bus.mispredict_cnt !== 16'd4) begin
            nerr++;
            $display("FAIL read_old_next got tgt=%h pc=%h cnt=%0d exp 00000900/00000900/4",
                     bus.pred_target, bus.redirect_pc, bus.mispredict_cnt);
        end
    endtask

    task automatic test_back_to_back();
        // not-taken, unmatched (idx 0 holds tag of 0x4000_0100)
        ex_set(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'h0000_0500);
        step();
        ex_set(1'b1, 1'b0, 1'b0, 32'h2000_0000, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        nvec++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_0104) begin
            nerr++;
            $display("FAIL b2b_first got redir=%b pc=%h exp 1/00000104",
                     bus.redirect, bus.redirect_pc);
        end
        step();
        ex_clear();
        nvec++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h2000_0040 || bus.mispredict_cnt !== 16'd6) begin
            nerr++;
            $display("FAIL b2b_second got redir=%b pc=%h cnt=%0d exp 1/20000040/6",
                     bus.redirect, bus.redirect_pc, bus.mispredict_cnt);
        end
        step();
        nvec++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0) begin
            nerr++;
            $display("FAIL b2b_end got redir=%b pc=%h exp 0/00000000",
                     bus.redirect, bus.redirect_pc);
        end
        bus.if_pc = 32'h4000_0100;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b0) begin
            nerr++;
            $display("FAIL conflict_evict got hit=%b exp 0", bus.pred_hit);
        end
        bus.if_pc = 32'h2000_0000;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h2000_0040) begin
            nerr++;
            $display("FAIL conflict_new got hit=%b tgt=%h exp 1/20000040",
                     bus.pred_hit, bus.pred_target);
        end
        bus.if_pc = 32'h0000_0100;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b0) begin
            nerr++;
            $display("FAIL no_alloc_not_taken got hit=%b exp 0", bus.pred_hit);
        end
    endtask

    task automatic test_ignored_and_wrap();
        // ex_valid with no kind flag: no effect
        ex_set(1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 32'h0000_0700, 1'b1, 32'h0);
        step();
        ex_clear();
        bus.if_pc = 32'h0000_0030;
        #1;
        nvec++;
        if (bus.redirect !== 1'b0 || bus.pred_hit !== 1'b0 || bus.mispredict_cnt !== 16'd6) begin
            nerr++;
            $display("FAIL ignored_pulse got redir=%b hit=%b cnt=%0d exp 0/0/6",
                     bus.redirect, bus.pred_hit, bus.mispredict_cnt);
        end
        ex_set(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 32'h0000_1234);
        step();
        ex_clear();
        nvec++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0 || bus.mispredict_cnt !== 16'd7) begin
            nerr++;
            $display("FAIL wrap got redir=%b pc=%h cnt=%0d exp 1/00000000/7",
                     bus.redirect, bus.redirect_pc, bus.mispredict_cnt);
        end
    endtask

    task automatic test_reset_mid_update();
        ex_set(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_0500, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        step();
        ex_clear();
        rst_n = 1'b1;
        #1;
        nvec++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.mispredict_cnt !== 16'd0) begin
            nerr++;
            $display("FAIL mid_reset_outputs got redir=%b pc=%h cnt=%0d exp 0/0/0",
                     bus.redirect, bus.redirect_pc, bus.mispredict_cnt);
        end
        bus.if_pc = 32'h0000_0010;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h0) begin
            nerr++;
            $display("FAIL mid_reset_no_write got hit=%b tgt=%h exp 0/0",
                     bus.pred_hit, bus.pred_target);
        end
        bus.if_pc = 32'h2000_0000;
        #1;
        nvec++;
        if (bus.pred_hit !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset_cleared got hit=%b exp 0", bus.pred_hit);
        end
        // first edge with rst_n high accepts an update
        ex_set(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0010, 32'h0000_0999, 1'b0, 32'h0);
        step();
        ex_clear();
        bus.if_pc = 32'h0000_0040;
        #1;
        nvec++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_0040 ||
            bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b1 || bus.mispredict_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL first_update got redir=%b pc=%h hit=%b tk=%b cnt=%0d exp 1/00000040/1/1/1",
                     bus.redirect, bus.redirect_pc, bus.pred_hit, bus.pred_taken, bus.mispredict_cnt);
        end
    endtask

    task automatic test_saturate();
        ex_set(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1'b1, 32'h0000_0600);
        repeat (99) @(posedge clk);
        #1;
        nvec++;
        if (bus.mispredict_cnt !== 16'd100 || bus.redirect_pc !== 32'h0000_0304) begin
            nerr++;
            $display("FAIL cnt_mid got cnt=%0d pc=%h exp 100/00000304",
                     bus.mispredict_cnt, bus.redirect_pc);
        end
        repeat (65440) @(posedge clk);
        #1;
        ex_clear();
        nvec++;
        if (bus.mispredict_cnt !== 16'hFFFF) begin
            nerr++;
            $display("FAIL cnt_saturate got cnt=%h exp ffff", bus.mispredict_cnt);
        end
        step();
        nvec++;
        if (bus.mispredict_cnt !== 16'hFFFF || bus.redirect !== 1'b0) begin
            nerr++;
            $display("FAIL cnt_hold got cnt=%h redir=%b exp ffff/0",
                     bus.mispredict_cnt, bus.redirect);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_jump();
        test_branch_correct();
        test_not_taken();
        test_read_old();
        test_back_to_back();
        test_ignored_and_wrap();
        test_reset_mid_update();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/jump_predict_btb.md
# jump_predict_btb

Parametrised fetch-side jump/branch target unit for the pipelined CPU. It computes J/JAL absolute targets from the region bits of the instruction's PC and the 26-bit index field, and caches resolved targets in a direct-mapped branch target buffer (BTB) of DEPTH entries. IF receives a same-cycle prediction. EX resolution updates the table and raises a registered redirect when the earlier prediction was wrong.

## Interface
- ADDR_W, 32, PC/target width; must be ≥ 29.
- DEPTH, 16, number of BTB entries; power of two, 2..256. IDX_W = log2(DEPTH) is derived internally.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- if_pc  in  ADDR_W  PC of the instruction being fetched.
- pred_hit  out  1  valid entry with matching tag for if_pc (combinational).
- pred_taken  out  1  predict redirect of fetch (combinational).
- pred_target  out  ADDR_W  predicted target; 0 when pred_hit = 0.
- ex_valid  in  1  a control instruction resolves in EX this cycle.
- ex_pc  in  ADDR_W  PC of the resolving instruction (not PC+4).
- ex_ins  in  32  instruction word of the resolving instruction.
- ex_is_jump  in  1  J/JAL; target is computed internally.
- ex_is_branch  in  1  conditional branch; target comes from ex_target.
- ex_taken  in  1  branch outcome; ignored for jumps, which are always taken.
- ex_target  in  ADDR_W  resolved branch target.
- ex_pred_taken  in  1  pred_taken carried down the pipe for this instruction.
- ex_pred_target  in  ADDR_W  pred_target carried down the pipe.
- redirect  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  ADDR_W  registered correct next PC; valid while redirect = 1.
- mispredict_cnt  out  16  saturating count of redirects.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag and target, plus ctr[1:0] when counters are compiled in.
- Jump target: jtarget = {ex_pc[ADDR_W-1:28], ex_ins[25:0], 2'b00}.
- Resolved values:
  - actual_taken = ex_is_jump | (ex_is_branch & ex_taken).
  - actual_target = ex_is_jump ? jtarget : ex_target.
  - next_pc = actual_taken ? actual_target : ex_pc + 4, with wrap modulo 2^ADDR_W.
- Mispredict = ex_valid & (ex_is_jump | ex_is_branch) & (actual_taken ≠ ex_pred_taken | (actual_taken & actual_target ≠ ex_pred_target)).
- Table update is gated by ex_valid & (ex_is_jump | ex_is_branch):
  - Taken: write valid = 1, tag and target at the index.
  - Not taken with a matching valid entry: behaviour per Configuration.
  - Not taken with no matching entry: no allocation.
  - An ex_valid pulse with both kind flags low is ignored entirely.
  - ex_is_jump and ex_is_branch both high: treat as a jump.
- Lookup reads the stored entry combinationally. An update to the same index in the same cycle is not visible until the next cycle (read-old).
- Tag conflicts: a taken allocation overwrites the indexed entry unconditionally.
- mispredict_cnt increments on each mispredict and holds at 16'hFFFF.

## Timing
- Prediction: zero-cycle, combinational from if_pc and the table registers.
- Table write takes effect at the rising edge ending the ex_valid cycle.
- redirect / redirect_pc are registered: they assert the cycle after the mispredicting ex_valid, for exactly one cycle. Back-to-back mispredicts give back-to-back pulses, each carrying its own next_pc.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits cleared; counters set to 2'b01.
  - redirect = 0, redirect_pc = 0, mispredict_cnt = 0.
  - Immediately after release, pred_hit = 0, pred_taken = 0, pred_target = 0.
- First update is accepted on the first rising edge with rst_n high.

## Configuration
- BTB_COUNTER_EN defined:
  - Each entry has a 2-bit saturating counter; pred_taken = pred_hit & ctr[1].
  - Taken new allocation: ctr = 2'b10; jump: ctr = 2'b11.
  - Taken hit: ctr increments, saturating at 3. Not-taken hit: ctr decrements, saturating at 0; entry stays valid.
- BTB_COUNTER_EN undefined:
  - No counters; pred_taken = pred_hit.
  - Not-taken branch with a matching valid entry clears that entry's valid bit.

## Test plan
- Reset then sweep if_pc over all DEPTH indices → pred_hit = 0 and pred_target = 0 everywhere; redirect = 0.
- J at ex_pc = 32'h4000_0100, ex_ins = 32'h0800_0040, ex_pred_taken = 0 → next cycle redirect = 1 and redirect_pc = 32'h4000_0100. Afterwards if_pc = 32'h4000_0100 gives pred_hit = pred_taken = 1, pred_target = 32'h4000_0100.
- Taken branch, correctly predicted (ex_pred_taken = 1, matching target) → redirect stays 0; mispredict_cnt unchanged.
- Not-taken branch at a cached PC 32'h0000_0020 with ex_pred_taken = 1 → redirect_pc = 32'h0000_0024.
  - Counters on: entry remains, ctr drops 10→01, pred_taken = 0.
  - Counters off: pred_hit = 0.
- Update and lookup at the same index in the same cycle → old entry returned that cycle, new entry next cycle. Assert rst_n low during an update → table cleared, no write lands.
- Ex_pc = 32'hFFFF_FFFC not-taken mispredict → redirect_pc = 0 (wrap). Force 65536 mispredicts → mispredict_cnt saturates at 16'hFFFF.
